cp0_timer_unit: RTL
===================

Name: cp0_timer_unit

Overview:
- Parametrised successor to the single-compare CP0 timer: one shared COUNT, NUM_TIMERS compare channels, programmable prescaler, sticky per-channel pending bits, and a synchronised hardware-interrupt path.
- Sits beside the CP0 register file and decodes its own CP0 register addresses.
- Drives the timer and hardware interrupt-pending (IP) inputs of the CP0 cause logic.

Parameters:
- DATA_WIDTH, 32, width of COUNT, COMPARE and register data.
- NUM_TIMERS, 2, compare channels, legal 1..6.
- HW_INT, 6, hardware interrupt lines.
- PRESCALE_WIDTH, 8, prescaler divisor width, legal 1..30.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- count_en  input  1  1 = prescaler/COUNT run; 0 = frozen (debug halt).
- reg_we  input  1  CP0 write strobe.
- reg_write_addr  input  5  CP0 write register number.
- reg_write  input  DATA_WIDTH  write data.
- reg_read_addr  input  5  CP0 read register number.
- reg_read  output  DATA_WIDTH  read data, combinational.
- hardware_int  input  HW_INT  asynchronous external interrupt lines.
- hw_ip  output  HW_INT  synchronised hardware_int.
- timer_pending  output  NUM_TIMERS  sticky per-channel match flags.
- timer_interrupt  output  1  OR of timer_pending.
- count  output  DATA_WIDTH  current COUNT.

Behaviour:
- Reset: asynchronous, active-low (rst_n). All of the following are 0: count, every compare[k], prescale, prescale_cnt, timer_pending, both synchroniser stages, timer_interrupt. reg_read is 0 while rst_n is 0.
- Register map:
  - 9 COUNT.
  - 11 COMPARE0.
  - 24+k COMPARE[k], k = 1..NUM_TIMERS-1.
  - 22 PRESCALE: divisor in bits [PRESCALE_WIDTH-1:0].
  - 23 PENDING: bits [NUM_TIMERS-1:0]; write-1-to-clear.
  - Unmapped addresses and COMPARE[k] with k >= NUM_TIMERS: reads return 0, writes are ignored.
- Prescaler:
  - When count_en=1: if prescale_cnt == prescale, then tick=1 and prescale_cnt <= 0; otherwise prescale_cnt increments.
  - prescale=0 gives a tick every cycle. prescale=N gives one tick every N+1 cycles.
  - When count_en=0: no tick, prescale_cnt holds.
- COUNT:
  - Increments by 1 on tick and wraps from all-ones to 0.
  - A COUNT write loads reg_write and clears prescale_cnt. It overrides the tick; no increment that cycle.
  - A PRESCALE write clears prescale_cnt.
- Match:
  - match[k] = tick && compare[k] != 0 && count == compare[k], evaluated on the pre-increment value.
  - On match, pending[k] is set at the next edge.
  - Result: pending asserts on the edge where count steps from compare[k] to compare[k]+1.
- Clearing pending:
  - A COMPARE[k] write loads compare[k] and clears pending[k]. The write wins over a same-cycle match[k].
  - A PENDING write clears pending bits where reg_write is 1.
  - A same-cycle match[k] together with a PENDING clear of bit k leaves the bit set (event not lost).
- timer_interrupt = |timer_pending, combinational from flops; no extra latency.
- hw_ip: two-flop synchroniser per line, 2-cycle latency, no stickiness.
- Read data returns register state before any same-cycle write takes effect.

Optional Feature:
- Macro: CP0_TIMER_AUTORELOAD_EN.
- Defined:
  - PRESCALE bit 31 (AUTO) is writable and readable, reset 0.
  - When AUTO=1 and match[0], COUNT loads 0 instead of incrementing, giving a periodic timer of period compare[0]+1 ticks.
  - pending[0] still sets.
  - A same-cycle COUNT write still wins over the reload.
- Undefined:
  - Bit 31 is ignored on write and reads 0.
  - COUNT always free-runs.

Test Plan:
1. Reset release, prescale=0, count_en=1, 10 cycles -> count=10; timer_pending=0; reg_read(15)=0.
2. compare0=5, run from count=0 -> pending[0]=1 and timer_interrupt=1 on the edge where count 5->6; COMPARE0 rewrite in the same cycle as the match -> pending[0] stays 0.
3. prescale=3 -> count increments every 4 cycles; count_en=0 for 7 cycles -> count and phase frozen, resume continues the same phase.
4. PENDING clear (write 1) coincident with a new match on channel 1 (NUM_TIMERS=2, compare1=8) -> pending[1] remains 1; a clear one cycle later -> 0.
5. COUNT write 32'hFFFF_FFFE, run 3 ticks -> wraps to 32'h0000_0001; compare=32'hFFFF_FFFF pends on the wrap edge.
6. hardware_int[2] pulse 3 cycles wide -> hw_ip[2] high 2 cycles later for 3 cycles. With CP0_TIMER_AUTORELOAD_EN, AUTO=1, compare0=4 -> count sequence 0,1,2,3,4,0,1.

Source files
------------

// File: rtl/cp0_timer_unit.sv
// CP0 timer block: shared COUNT, NUM_TIMERS compare channels with sticky pending, prescaler, hw interrupt synchroniser.
// Optional CP0_TIMER_AUTORELOAD_EN: PRESCALE[31] (AUTO) reloads COUNT to 0 on a channel-0 match.
module cp0_timer_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_TIMERS     = 2,
    parameter int HW_INT         = 6,
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  count_en,
    input  logic                  reg_we,
    input  logic [4:0]            reg_write_addr,
    input  logic [DATA_WIDTH-1:0] reg_write,
    input  logic [4:0]            reg_read_addr,
    output logic [DATA_WIDTH-1:0] reg_read,
    input  logic [HW_INT-1:0]     hardware_int,
    output logic [HW_INT-1:0]     hw_ip,
    output logic [NUM_TIMERS-1:0] timer_pending,
    output logic                  timer_interrupt,
    output logic [DATA_WIDTH-1:0] count
);

    localparam logic [4:0] ADDR_COUNT    = 5'd9;
    localparam logic [4:0] ADDR_PRESCALE = 5'd22;
    localparam logic [4:0] ADDR_PENDING  = 5'd23;

    // COMPARE0 keeps the legacy address; extra channels live at 24+k.
    function automatic logic [4:0] comp_addr(input int k);
        return (k == 0) ? 5'd11 : 5'(24 + k);
    endfunction

    logic [DATA_WIDTH-1:0]     compare [NUM_TIMERS];
    logic [PRESCALE_WIDTH-1:0] prescale;
    logic [PRESCALE_WIDTH-1:0] prescale_cnt;
    logic [HW_INT-1:0]         sync_q1;
    logic [HW_INT-1:0]         sync_q2;
    logic [NUM_TIMERS-1:0]     comp_we;
    logic [NUM_TIMERS-1:0]     match;
    logic                      tick;
    logic                      count_we;
    logic                      prescale_we;
    logic                      pending_we;
    logic                      count_reload;
`ifdef CP0_TIMER_AUTORELOAD_EN
    logic                      auto_reload;
`endif

    assign count_we    = reg_we && (reg_write_addr == ADDR_COUNT);
    assign prescale_we = reg_we && (reg_write_addr == ADDR_PRESCALE);
    assign pending_we  = reg_we && (reg_write_addr == ADDR_PENDING);
    assign tick        = count_en && (prescale_cnt == prescale);

    always_comb begin
        comp_we = '0;
        match   = '0;
        for (int k = 0; k < NUM_TIMERS; k++) begin
            comp_we[k] = reg_we && (reg_write_addr == comp_addr(k));
            match[k]   = tick && (compare[k] != '0) && (count == compare[k]);
        end
    end

`ifdef CP0_TIMER_AUTORELOAD_EN
    assign count_reload = auto_reload && match[0];
`else
    assign count_reload = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count        <= '0;
            prescale     <= '0;
            prescale_cnt <= '0;
        end else begin
            if (count_we)
                count <= reg_write;
            else if (tick)
                count <= count_reload ? '0 : count + 1'b1;

            if (prescale_we)
                prescale <= reg_write[PRESCALE_WIDTH-1:0];

            if (count_we || prescale_we)
                prescale_cnt <= '0;
            else if (count_en)
                prescale_cnt <= tick ? '0 : prescale_cnt + 1'b1;
        end
    end

`ifdef CP0_TIMER_AUTORELOAD_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            auto_reload <= 1'b0;
        else if (prescale_we)
            auto_reload <= reg_write[31];
    end
`endif

    // Priority per bit: COMPARE write clears, then a match sets, then a W1C clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_pending <= '0;
            for (int k = 0; k < NUM_TIMERS; k++)
                compare[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_TIMERS; k++) begin
                if (comp_we[k]) begin
                    compare[k]       <= reg_write;
                    timer_pending[k] <= 1'b0;
                end else if (match[k]) begin
                    timer_pending[k] <= 1'b1;
                end else if (pending_we && reg_write[k]) begin
                    timer_pending[k] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= hardware_int;
            sync_q2 <= sync_q1;
        end
    end

    assign hw_ip           = sync_q2;
    assign timer_interrupt = |timer_pending;

    always_comb begin
        reg_read = '0;
        if (rst_n) begin
            case (reg_read_addr)
                ADDR_COUNT:    reg_read = count;
                ADDR_PRESCALE: begin
                    reg_read[PRESCALE_WIDTH-1:0] = prescale;
`ifdef CP0_TIMER_AUTORELOAD_EN
                    reg_read[31] = auto_reload;
`endif
                end
                ADDR_PENDING:  reg_read[NUM_TIMERS-1:0] = timer_pending;
                default: begin
                    for (int k = 0; k < NUM_TIMERS; k++)
                        if (reg_read_addr == comp_addr(k))
                            reg_read = compare[k];
                end
            endcase
        end
    end

endmodule
